// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the reservation station: entry layout, CDB bundle,
// micro-op codes and the operand snoop helper used by both issue and wakeup paths.
package reservation_station_pkg;

    localparam int RS_SIZE = 16;
    localparam int IDX_W   = 4;
    localparam int ROB_W   = 4;
    localparam int DATA_W  = 32;
    localparam int OP_W    = 6;
    localparam int SHAMT_W = 6;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 6'd0,
        OP_ADD   = 6'd1,
        OP_SUB   = 6'd2,
        OP_ADDI  = 6'd3,
        OP_SLLI  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_JAL   = 6'd6,
        OP_LUI   = 6'd7,
        OP_AUIPC = 6'd8
    } rs_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic [ROB_W-1:0]  tag;
        logic              rdy;
    } opnd_t;

    typedef struct packed {
        logic               busy;
        logic [OP_W-1:0]    op;
        logic [DATA_W-1:0]  imm;
        logic [DATA_W-1:0]  pc;
        logic [SHAMT_W-1:0] shamt;
        logic [ROB_W-1:0]   dest;
        opnd_t              rs1;
        opnd_t              rs2;
    } rs_entry_t;

    typedef struct packed {
        logic              valid;
        logic [ROB_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

    // A waiting operand captures the first matching broadcast; the ALU bus wins a tie.
    // Operands already marked ready are returned untouched.
    function automatic opnd_t snoop(input opnd_t o, input cdb_t alu, input cdb_t slb);
        opnd_t r;
        r = o;
        if (!o.rdy) begin
            if (alu.valid && (alu.tag == o.tag)) begin
                r.val = alu.data;
                r.rdy = 1'b1;
            end else if (slb.valid && (slb.tag == o.tag)) begin
                r.val = slb.data;
                r.rdy = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reservation_station_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request bit is set
// and the index of the lowest one.
module reservation_station_prio_enc #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = |req;
        idx   = '0;
        // Scan downwards so the lowest set bit is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: buffers issued ALU-class instructions, wakes operands from
// the ALU and load CDBs, and dispatches the lowest-index ready entry each cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               has_misbranch,
    input  logic               issue_rs,
    input  logic [OP_W-1:0]    rs_op,
    input  logic [DATA_W-1:0]  rs_imm,
    input  logic [DATA_W-1:0]  rs_pc,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [ROB_W-1:0]   rs_rd_robnum,
    input  logic [DATA_W-1:0]  rs_rs1_oprand,
    input  logic [DATA_W-1:0]  rs_rs2_oprand,
    input  logic [ROB_W-1:0]   rs_rs1_robnum,
    input  logic [ROB_W-1:0]   rs_rs2_robnum,
    input  logic               rs_rs1_ready,
    input  logic               rs_rs2_ready,
    input  logic               alu_cdb_valid,
    input  logic [ROB_W-1:0]   alu_cdb_robnum,
    input  logic [DATA_W-1:0]  alu_cdb_data,
    input  logic               slb_cdb_valid,
    input  logic [ROB_W-1:0]   slb_cdb_robnum,
    input  logic [DATA_W-1:0]  slb_cdb_data,
    output logic               rs_avail,
    output logic               alu_valid,
    output logic [OP_W-1:0]    alu_op,
    output logic [DATA_W-1:0]  alu_imm,
    output logic [DATA_W-1:0]  alu_pc,
    output logic [SHAMT_W-1:0] alu_shamt,
    output logic [ROB_W-1:0]   alu_rob_num,
    output logic [DATA_W-1:0]  alu_rs1,
    output logic [DATA_W-1:0]  alu_rs2
);

    rs_entry_t entries_q [RS_SIZE];
    rs_entry_t entries_d [RS_SIZE];

    logic               alu_valid_q,   alu_valid_d;
    logic [OP_W-1:0]    alu_op_q,      alu_op_d;
    logic [DATA_W-1:0]  alu_imm_q,     alu_imm_d;
    logic [DATA_W-1:0]  alu_pc_q,      alu_pc_d;
    logic [SHAMT_W-1:0] alu_shamt_q,   alu_shamt_d;
    logic [ROB_W-1:0]   alu_rob_num_q, alu_rob_num_d;
    logic [DATA_W-1:0]  alu_rs1_q,     alu_rs1_d;
    logic [DATA_W-1:0]  alu_rs2_q,     alu_rs2_d;

    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] free_minus1;
    logic [RS_SIZE-1:0] ready_vec;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               ready_found;
    logic [IDX_W-1:0]   ready_idx;

    cdb_t  alu_cdb;
    cdb_t  slb_cdb;
    opnd_t in_rs1;
    opnd_t in_rs2;

    assign alu_cdb = '{valid: alu_cdb_valid, tag: alu_cdb_robnum, data: alu_cdb_data};
    assign slb_cdb = '{valid: slb_cdb_valid, tag: slb_cdb_robnum, data: slb_cdb_data};

    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_vec
            assign busy_vec[gi]  = entries_q[gi].busy;
            assign ready_vec[gi] = entries_q[gi].busy & entries_q[gi].rs1.rdy & entries_q[gi].rs2.rdy;
        end
    endgenerate

    assign free_vec    = ~busy_vec;
    assign free_minus1 = free_vec - RS_SIZE'(1);
    // Clearing the lowest free bit leaves something only when two or more slots are free.
    assign rs_avail    = |(free_vec & free_minus1);

    reservation_station_prio_enc #(.N(RS_SIZE), .W(IDX_W)) u_free_enc (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    reservation_station_prio_enc #(.N(RS_SIZE), .W(IDX_W)) u_ready_enc (
        .req   (ready_vec),
        .found (ready_found),
        .idx   (ready_idx)
    );

    always_comb begin
        in_rs1 = '{val: rs_rs1_oprand, tag: rs_rs1_robnum, rdy: rs_rs1_ready};
        in_rs2 = '{val: rs_rs2_oprand, tag: rs_rs2_robnum, rdy: rs_rs2_ready};
        in_rs1 = snoop(in_rs1, alu_cdb, slb_cdb);
        in_rs2 = snoop(in_rs2, alu_cdb, slb_cdb);
    end

    always_comb begin
        entries_d     = entries_q;
        alu_valid_d   = 1'b0;
        alu_op_d      = alu_op_q;
        alu_imm_d     = alu_imm_q;
        alu_pc_d      = alu_pc_q;
        alu_shamt_d   = alu_shamt_q;
        alu_rob_num_d = alu_rob_num_q;
        alu_rs1_d     = alu_rs1_q;
        alu_rs2_d     = alu_rs2_q;

        if (rdy) begin
            if (has_misbranch) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    entries_d[i].busy = 1'b0;
                end
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (entries_q[i].busy) begin
                        entries_d[i].rs1 = snoop(entries_q[i].rs1, alu_cdb, slb_cdb);
                        entries_d[i].rs2 = snoop(entries_q[i].rs2, alu_cdb, slb_cdb);
                    end
                end

                // Selection uses registered readiness, so a freshly woken entry waits a cycle.
                if (ready_found) begin
                    entries_d[ready_idx].busy = 1'b0;
                    alu_valid_d   = 1'b1;
                    alu_op_d      = entries_q[ready_idx].op;
                    alu_imm_d     = entries_q[ready_idx].imm;
                    alu_pc_d      = entries_q[ready_idx].pc;
                    alu_shamt_d   = entries_q[ready_idx].shamt;
                    alu_rob_num_d = entries_q[ready_idx].dest;
                    alu_rs1_d     = entries_q[ready_idx].rs1.val;
                    alu_rs2_d     = entries_q[ready_idx].rs2.val;
                end

                // free_idx comes from the registered busy vector, so it never aliases the
                // slot being dispatched this cycle.
                if (issue_rs && free_found) begin
                    entries_d[free_idx] = '{busy: 1'b1, op: rs_op, imm: rs_imm, pc: rs_pc,
                                            shamt: shamt, dest: rs_rd_robnum,
                                            rs1: in_rs1, rs2: in_rs2};
                end
            end
        end
    end

    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entries_q[gi] <= '0;
                end else begin
                    entries_q[gi] <= entries_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_valid_q   <= 1'b0;
            alu_op_q      <= '0;
            alu_imm_q     <= '0;
            alu_pc_q      <= '0;
            alu_shamt_q   <= '0;
            alu_rob_num_q <= '0;
            alu_rs1_q     <= '0;
            alu_rs2_q     <= '0;
        end else begin
            alu_valid_q   <= alu_valid_d;
            alu_op_q      <= alu_op_d;
            alu_imm_q     <= alu_imm_d;
            alu_pc_q      <= alu_pc_d;
            alu_shamt_q   <= alu_shamt_d;
            alu_rob_num_q <= alu_rob_num_d;
            alu_rs1_q     <= alu_rs1_d;
            alu_rs2_q     <= alu_rs2_d;
        end
    end

    assign alu_valid   = alu_valid_q;
    assign alu_op      = alu_op_q;
    assign alu_imm     = alu_imm_q;
    assign alu_pc      = alu_pc_q;
    assign alu_shamt   = alu_shamt_q;
    assign alu_rob_num = alu_rob_num_q;
    assign alu_rs1     = alu_rs1_q;
    assign alu_rs2     = alu_rs2_q;

    // Issuing into a full station is an upstream protocol error; the write is dropped.
    issue_when_full: assert property (@(posedge clk) disable iff (!rst)
        !(issue_rs && rdy && !has_misbranch && !free_found))
        else $error("reservation_station: issue into full station dropped");

endmodule
